// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester behind a cmd/rsp handshake.
// Define APB_MASTER_TIMEOUT_EN to bound ACCESS wait states to TIMEOUT_CYCLES.
module apb_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] prdata
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state;
  logic   accept;
  logic   timeout;

  assign accept = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;

  // Fires on the last tolerated stalled ACCESS cycle.
  assign timeout = !pready &&
                   (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_ready <= !accept;
          if (accept) begin
            state   <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_wdata;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (pready || timeout) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            if (pready) begin
              rsp_err <= pslverr;
              if (!pwrite) begin
                rsp_rdata <= prdata;
              end
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: vector table plus scoreboarded responses for apb_master.
// Honours APB_MASTER_TIMEOUT_EN the same way the design does.
module tb_apb_master;

  logic       pclk = 1'b0;
  logic       preset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic       pready;
  logic       pslverr;
  logic [7:0] prdata;

  int nvec  = 0;
  int nfail = 0;

  always #5 pclk = ~pclk;

  apb_master dut (
    .pclk      (pclk),
    .preset    (preset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .prdata    (prdata)
  );

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] prd;
    logic       slv;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  exp_t sb[$];
  logic prev_rv = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Response monitor: every rsp_valid pulse retires one scoreboard entry.
  always @(negedge pclk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
      check("rsp_single_pulse", 32'(prev_rv), 32'd0);
    end
    prev_rv = rsp_valid;
  end

  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge pclk);
      n++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    sb.push_back('{v.exp_rdata, v.exp_err});
    @(negedge pclk);
    cmd_valid = 1'b0;
    check("setup_phase",
          32'({psel, penable, pwrite, paddr, pwdata, cmd_ready}),
          32'({1'b1, 1'b0, v.wr, v.addr, v.wdata, 1'b0}));
    // Completer noise in SETUP must not complete the transfer.
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 8'hEE;
    for (int i = 0; i <= v.waits; i++) begin
      @(negedge pclk);
      check("access_hold",
            32'({psel, penable, pwrite, paddr, pwdata}),
            32'({1'b1, 1'b1, v.wr, v.addr, v.wdata}));
      pready  = (i == v.waits);
      pslverr = (i == v.waits) ? v.slv : ~v.slv;
      prdata  = (i == v.waits) ? v.prd : ~v.prd;
    end
    @(negedge pclk);
    pready = 1'b0;
    check("rsp_cycle",
          32'({psel, penable, cmd_ready, rsp_valid}),
          32'({1'b0, 1'b0, 1'b1, 1'b1}));
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 8'h12, 8'hA5, 0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h34, 8'h00, 2, 8'h5C, 1'b0, 8'h5C, 1'b0};
    vecs[2] = '{1'b1, 8'h56, 8'h3C, 0, 8'h00, 1'b1, 8'h5C, 1'b1};
    vecs[3] = '{1'b0, 8'h78, 8'h00, 1, 8'hC3, 1'b1, 8'hC3, 1'b1};
    vecs[4] = '{1'b1, 8'hFF, 8'hFF, 3, 8'h00, 1'b0, 8'hC3, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 8'hAB, 8'h00, 0, 8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{1'b1, 8'h01, 8'h00, 1, 8'h00, 1'b0, 8'hFF, 1'b0};

    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 8'h00;
    repeat (3) @(negedge pclk);
    check("reset_state",
          32'({psel, penable, pwrite, paddr, pwdata,
               rsp_valid, rsp_err, rsp_rdata, cmd_ready}),
          32'd0);
    preset = 1'b0;
    @(negedge pclk);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // pready held low in ACCESS.
    pready    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h9A;
`ifdef APB_MASTER_TIMEOUT_EN
    sb.push_back('{8'h00, 1'b1});
    n = 0;
    do begin
      @(negedge pclk);
      n++;
      if (n == 1) cmd_valid = 1'b0;
    end while (!rsp_valid && n < 200);
    check("timeout_latency", 32'(n), 32'd17);
    check("timeout_idle", 32'({psel, penable, cmd_ready}), 32'b001);
`else
    n = 0;
    do begin
      @(negedge pclk);
      n++;
      if (n == 1) cmd_valid = 1'b0;
    end while (!rsp_valid && n < 120);
    check("stall_hold", 32'({psel, penable, paddr}),
          32'({1'b1, 1'b1, 8'h9A}));
    check("stall_no_rsp", 32'(rsp_valid), 32'd0);
    pready = 1'b1;
    prdata = 8'h77;
    sb.push_back('{8'h77, 1'b0});
    @(negedge pclk);
    pready = 1'b0;
    check("stall_release", 32'(rsp_valid), 32'd1);
`endif

    // Reset in ACCESS: outputs drop without a clock edge.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h5A;
    cmd_wdata = 8'h99;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    check("abort_in_access", 32'({psel, penable}), 32'b11);
    #2 preset = 1'b1;
    #1;
    check("abort_async",
          32'({psel, penable, paddr, pwdata, cmd_ready, rsp_valid}),
          32'd0);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    check("abort_release", 32'({cmd_ready, psel, rsp_valid}),
          32'b100);

    // cmd_valid held across two commands.
    pready    = 1'b1;
    pslverr   = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h21;
    cmd_wdata = 8'h11;
    sb.push_back('{8'h00, 1'b0});
    sb.push_back('{8'h00, 1'b0});
    @(negedge pclk);
    check("b2b_first_setup", 32'({psel, penable, paddr}),
          32'({1'b1, 1'b0, 8'h21}));
    cmd_addr  = 8'h22;
    cmd_wdata = 8'h22;
    @(negedge pclk);
    @(negedge pclk);
    check("b2b_first_rsp", 32'({rsp_valid, cmd_ready}), 32'b11);
    @(negedge pclk);
    cmd_valid = 1'b0;
    check("b2b_second_setup",
          32'({psel, penable, paddr, pwdata, rsp_valid}),
          32'({1'b1, 1'b0, 8'h22, 8'h22, 1'b0}));
    @(negedge pclk);
    @(negedge pclk);
    check("b2b_second_rsp", 32'({rsp_valid, cmd_ready}), 32'b11);
    @(negedge pclk);
    pready = 1'b0;
    check("b2b_quiet", 32'({rsp_valid, cmd_ready, psel}), 32'b010);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of data buses.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, width of address buses.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15, maximum ACCESS wait cycles (used only with APB_MASTER_TIMEOUT_EN).
REQ-004 SHALL have port pclk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port preset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-008 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr  input  ADDR_WIDTH  transfer address.
REQ-010 SHALL have port cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle transfer-complete pulse.
REQ-012 SHALL have port rsp_rdata  output  DATA_WIDTH  read data of completed read.
REQ-013 SHALL have port rsp_err  output  1  error status of completed transfer.
REQ-014 SHALL have ports psel, penable, pwrite (output, 1), paddr (output, ADDR_WIDTH), pwdata (output, DATA_WIDTH): APB requester signals.
REQ-015 SHALL have ports pready, pslverr (input, 1), prdata (input, DATA_WIDTH): APB completer signals.

Function
REQ-016 SHALL implement states IDLE, SETUP, ACCESS; all APB and rsp outputs registered.
REQ-017 SHALL drive cmd_ready=1 only in IDLE; command accepted on edge where cmd_valid&&cmd_ready.
REQ-018 On accept SHALL load pwrite/paddr/pwdata from cmd_*, set psel=1, penable=0, go SETUP.
REQ-019 SETUP SHALL last exactly one cycle, then set penable=1, go ACCESS.
REQ-020 ACCESS SHALL hold psel=penable=1 and pwrite/paddr/pwdata stable until pready=1 sampled.
REQ-021 On pready=1 in ACCESS SHALL clear psel/penable, go IDLE, pulse rsp_valid next cycle with rsp_err=pslverr; rsp_rdata=prdata for reads, unchanged for writes.
REQ-022 Minimum occupancy SHALL be 3 cycles (accept, SETUP, ACCESS); rsp_valid and cmd_ready=1 coincide; no back-to-back without IDLE.
REQ-023 pready, pslverr, prdata SHALL be ignored outside ACCESS.
REQ-024 rsp_valid SHALL have no backpressure; never high two consecutive cycles.

Reset
REQ-025 While preset=1 SHALL force IDLE, psel=penable=pwrite=0, paddr=pwdata=0, rsp_valid=rsp_err=0, rsp_rdata=0, cmd_ready=0, wait counter=0.
REQ-026 Reset mid-transfer SHALL abort immediately with no rsp_valid; cmd_ready=1 first cycle after release.

Configuration
REQ-027 With APB_MASTER_TIMEOUT_EN defined, SHALL count ACCESS cycles with pready=0; at TIMEOUT_CYCLES SHALL abort as REQ-021 with rsp_err=1, rsp_rdata=0; counter clears on entering ACCESS.
REQ-028 Without APB_MASTER_TIMEOUT_EN, SHALL wait indefinitely in ACCESS; no counter logic present.

Verification
REQ-029 Write 0x12/0xA5, pready=1 -> psel rises 1 cycle after accept, penable 1 later, rsp_valid=1,rsp_err=0 3 cycles after accept.
REQ-030 Read 0x34, completer 2 wait states, prdata=0x5C -> penable high 3 cycles, paddr stable, rsp_rdata=0x5C.
REQ-031 Write with pslverr=1 at pready -> rsp_err=1 for one cycle, then IDLE.
REQ-032 preset=1 during ACCESS -> psel/penable 0 without clock edge, no rsp_valid, cmd_ready=1 after release.
REQ-033 pready held 0: with macro rsp_valid=1, rsp_err=1 after 15 wait cycles; without macro ACCESS held 100+ cycles.
REQ-034 cmd_valid held across two commands -> two separate transfers, second accepted on rsp_valid cycle.
